mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  SHALL be asynchronous, active-low.
REQ-004 start  input  1  request; SHALL be sampled only in IDLE.
REQ-005 op  input  1  operation: 0 = MUL, 1 = DIV.
REQ-006 a  input  WIDTH  multiplicand or dividend, two's complement.
REQ-007 b  input  WIDTH  multiplier or divisor, two's complement.
REQ-008 busy  output  1  SHALL be high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 hi  output  WIDTH  MUL: upper product half; DIV: remainder; feeds the HI register.
REQ-011 lo  output  WIDTH  MUL: lower product half; DIV: quotient; feeds the LO register.
REQ-012 div_by_zero  output  1  valid with done; held until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, MUL_ITER, DIV_ITER, DIV_FIX and DONE.
REQ-014 IDLE with start=1 SHALL capture a, b and op on that edge, clear div_by_zero, and go to MUL_ITER (op=0) or DIV_ITER (op=1).
REQ-015 start SHALL be ignored outside IDLE; operands SHALL NOT change while busy=1.
REQ-016 MUL SHALL use radix-4 Booth bit-pair recoding: WIDTH/2 MUL_ITER cycles, then DONE.
REQ-017 MUL result {hi,lo} SHALL equal the exact 2*WIDTH-bit signed product a*b.
REQ-018 MUL latency SHALL be WIDTH/2+1 cycles from the accepting edge to done=1 (17 for WIDTH=32).
REQ-019 DIV SHALL use non-restoring division on magnitudes: WIDTH DIV_ITER cycles, then one DIV_FIX cycle (remainder correction and sign application), then DONE.
REQ-020 DIV latency SHALL be WIDTH+2 cycles from the accepting edge to done=1 (34 for WIDTH=32).
REQ-021 DIV quotient SHALL truncate toward zero; the remainder sign SHALL follow the dividend.
REQ-022 DIV with b=0 SHALL skip DIV_ITER and enter DONE on the next edge with lo = all-ones, hi = a and div_by_zero=1.
REQ-023 DIV of the most-negative value by -1 SHALL give lo = most-negative and hi = 0, with no flag.
REQ-024 DONE SHALL assert done for exactly one cycle and return to IDLE; a start present during DONE SHALL be ignored.
REQ-025 hi and lo SHALL update only on the DONE-entry edge and hold their values until the next DONE entry.

Reset
REQ-026 Assertion of reset, including mid-operation, SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0 and clear all internal operand and accumulator registers.
REQ-027 The first rising clk edge after reset deassertion SHALL be able to accept start.

Configuration
REQ-028 Macro MUL_DIV_UNIT_DIV_EN SHALL compile the divider in; when defined, behaviour SHALL be per REQ-019 to REQ-023.
REQ-029 Without MUL_DIV_UNIT_DIV_EN:
  - DIV_ITER and DIV_FIX SHALL NOT exist.
  - op=1 SHALL go directly to DONE with hi=0, lo=0 and div_by_zero=0.
  - MUL behaviour SHALL be unchanged.

Structure
REQ-030 Shared package mul_div_pkg SHALL hold the op encodings, the FSM state enumeration and the default WIDTH constant.
REQ-031 Radix-4 Booth digit selection (3-bit window to 0, +/-a, +/-2a) SHALL be a combinational sub-module mul_div_booth_sel.

Verification
REQ-032 MUL a=32'h07F00000, b=268 -> done after 17 cycles; hi=32'h00000008, lo=32'h4F400000.
REQ-033 MUL a=-6, b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFD6; MUL a=b=32'h80000000 -> hi=32'h40000000, lo=0.
REQ-034 DIV a=268, b=40 -> done after 34 cycles; lo=6, hi=28. DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-035 DIV a=5, b=0 -> done 1 cycle after accept; lo=32'hFFFFFFFF, hi=5, div_by_zero=1.
REQ-036 start pulsed during MUL_ITER -> ignored, result unchanged. reset asserted at MUL_ITER cycle 8 -> busy, done, hi, lo = 0 immediately; a new MUL 3*4 afterwards -> lo=12, hi=0.
REQ-037 Build without MUL_DIV_UNIT_DIV_EN: DIV a=268, b=40 -> done 1 cycle after accept; hi=lo=0; REQ-032 still passes.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// DIV_ITER and DIV_FIX exist only when MUL_DIV_UNIT_DIV_EN is defined.
package mul_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_ITER = 3'd1,
`ifdef MUL_DIV_UNIT_DIV_EN
        DIV_ITER = 3'd2,
        DIV_FIX  = 3'd3,
`endif
        DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/mul_div_booth_sel.sv
// Radix-4 Booth digit selection: maps a 3-bit multiplier window to a
// sign-extended partial product of 0, +/-a or +/-2a.
module mul_div_booth_sel
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       window,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH+1:0] pp
);

    logic [WIDTH+1:0] one_x;
    logic [WIDTH+1:0] two_x;

    assign one_x = {{2{mcand[WIDTH-1]}}, mcand};
    assign two_x = {mcand[WIDTH-1], mcand, 1'b0};

    always_comb begin
        pp = '0;
        case (window)
            3'b001, 3'b010: pp = one_x;
            3'b011:         pp = two_x;
            3'b100:         pp = -two_x;
            3'b101, 3'b110: pp = -one_x;
            default:        pp = '0;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiplier (radix-4 Booth) with optional non-restoring
// divider, compiled in by defining MUL_DIV_UNIT_DIV_EN.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output state_t           dbg_state
);

    // Handshake: start is taken on a rising edge only while busy is low;
    // done pulses for one cycle with hi/lo/div_by_zero valid, and they hold.
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH+1:0] mul_u, mul_sum, mul_u_nxt, pp;
    logic [WIDTH-1:0] mul_l, mul_l_nxt;
    logic             mul_e;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             dbz_q;

    mul_div_booth_sel #(.WIDTH(WIDTH)) u_booth (
        .window ({mul_l[1:0], mul_e}),
        .mcand  (a_q),
        .pp     (pp)
    );

    // Accumulate the digit into the upper half, then shift the pair right by 2.
    assign mul_sum   = mul_u + pp;
    assign mul_u_nxt = {{2{mul_sum[WIDTH+1]}}, mul_sum[WIDTH+1:2]};
    assign mul_l_nxt = {mul_sum[1:0], mul_l[WIDTH-1:2]};

`ifdef MUL_DIV_UNIT_DIV_EN
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] div_q, div_d, a_mag, b_mag, rem_mag, q_out, r_out;
    logic [WIDTH+1:0] div_r, div_shift, div_r_nxt;

    assign a_mag     = a[WIDTH-1] ? -a : a;
    assign b_mag     = b[WIDTH-1] ? -b : b;
    assign div_shift = {div_r[WIDTH:0], div_q[WIDTH-1]};
    assign div_r_nxt = div_r[WIDTH+1] ? div_shift + {2'b00, div_d}
                                      : div_shift - {2'b00, div_d};
    // A negative final remainder is pulled back by one divisor.
    assign rem_mag   = div_r[WIDTH+1] ? div_r[WIDTH-1:0] + div_d : div_r[WIDTH-1:0];
    assign q_out     = (a_neg ^ b_neg) ? -div_q : div_q;
    assign r_out     = a_neg ? -rem_mag : rem_mag;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) state_nxt = MUL_ITER;
`ifdef MUL_DIV_UNIT_DIV_EN
                    else if (b == '0) state_nxt = DONE;
                    else              state_nxt = DIV_ITER;
`else
                    else              state_nxt = DONE;
`endif
                end
            end
            MUL_ITER: if (cnt == '0) state_nxt = DONE;
`ifdef MUL_DIV_UNIT_DIV_EN
            DIV_ITER: if (cnt == '0) state_nxt = DIV_FIX;
            DIV_FIX:  state_nxt = DONE;
`endif
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            a_q   <= '0;
            mul_u <= '0;
            mul_l <= '0;
            mul_e <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            div_q <= '0;
            div_d <= '0;
            div_r <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        mul_u <= '0;
                        mul_l <= b;
                        mul_e <= 1'b0;
                        dbz_q <= 1'b0;
                        cnt   <= CW'(WIDTH / 2 - 1);
                        if (op == OP_DIV) begin
`ifdef MUL_DIV_UNIT_DIV_EN
                            a_neg <= a[WIDTH-1];
                            b_neg <= b[WIDTH-1];
                            div_q <= a_mag;
                            div_d <= b_mag;
                            div_r <= '0;
                            cnt   <= CW'(WIDTH - 1);
                            if (b == '0) begin
                                hi_q  <= a;
                                lo_q  <= '1;
                                dbz_q <= 1'b1;
                            end
`else
                            hi_q <= '0;
                            lo_q <= '0;
`endif
                        end
                    end
                end
                MUL_ITER: begin
                    mul_u <= mul_u_nxt;
                    mul_l <= mul_l_nxt;
                    mul_e <= mul_l[1];
                    cnt   <= cnt - CW'(1);
                    if (cnt == '0) begin
                        hi_q <= mul_u_nxt[WIDTH-1:0];
                        lo_q <= mul_l_nxt;
                    end
                end
`ifdef MUL_DIV_UNIT_DIV_EN
                DIV_ITER: begin
                    div_r <= div_r_nxt;
                    div_q <= {div_q[WIDTH-2:0], ~div_r_nxt[WIDTH+1]};
                    cnt   <= cnt - CW'(1);
                end
                DIV_FIX: begin
                    hi_q <= r_out;
                    lo_q <= q_out;
                end
`endif
                default: ;
            endcase
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state;

endmodule
